// File: rtl/boron_rev_key_sched.sv
// Reverse-order BORON round-key generator: expands the 80-bit key forward to
// RK_ROUNDS, then streams RK_ROUNDS..RK_0 by undoing one schedule step per handshake.
module boron_rev_key_sched #(
    parameter int unsigned ROUNDS = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [79:0] key_in,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [63:0] round_key,
    output logic [4:0]  round_idx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned KEY_W = 80;
    localparam int unsigned RK_W  = 64;
    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_STREAM
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
            4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
            4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
            4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;  4'h1: y = 4'h3;  4'h2: y = 4'h9;  4'h3: y = 4'hE;
            4'h4: y = 4'h1;  4'h5: y = 4'hD;  4'h6: y = 4'hF;  4'h7: y = 4'h4;
            4'h8: y = 4'hC;  4'h9: y = 4'h5;  4'hA: y = 4'h7;  4'hB: y = 4'h2;
            4'hC: y = 4'h6;  4'hD: y = 4'h8;  4'hE: y = 4'h0;  default: y = 4'hB;
        endcase
        return y;
    endfunction

    // Forward step: rotl 13, S-box on low nibble, round index into bits 63:59.
    function automatic logic [KEY_W-1:0] fwd_step(input logic [KEY_W-1:0] k,
                                                  input logic [IDX_W-1:0] i);
        logic [KEY_W-1:0] t;
        t         = {k[66:0], k[79:67]};
        t[3:0]    = sbox(t[3:0]);
        t[63:59]  = t[63:59] ^ i;
        return t;
    endfunction

    // Exact inverse of fwd_step, operations applied in reverse order.
    function automatic logic [KEY_W-1:0] inv_step(input logic [KEY_W-1:0] k,
                                                  input logic [IDX_W-1:0] i);
        logic [KEY_W-1:0] t;
        t         = k;
        t[63:59]  = t[63:59] ^ i;
        t[3:0]    = inv_sbox(t[3:0]);
        return {t[12:0], t[79:13]};
    endfunction

    state_t            r_state;
    logic [KEY_W-1:0]  r_key;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_valid;
    logic [RK_W-1:0]   r_round_key;
    logic              r_busy;
    logic              r_done;

    logic [KEY_W-1:0]  w_fwd;
    logic [KEY_W-1:0]  w_inv;

    assign w_fwd = fwd_step(r_key, r_cnt);
    assign w_inv = inv_step(r_key, r_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_round_key <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key   <= key_in;
                        r_cnt   <= IDX_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    r_key <= w_fwd;
                    if (r_cnt == IDX_W'(ROUNDS)) begin
                        r_idx       <= IDX_W'(ROUNDS);
                        r_valid     <= 1'b1;
                        r_round_key <= w_fwd[RK_W-1:0];
                        r_state     <= S_STREAM;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                S_STREAM: begin
                    // Outputs and key hold while the consumer stalls.
                    if (rk_ready) begin
                        if (r_idx != '0) begin
                            r_key       <= w_inv;
                            r_idx       <= r_idx - IDX_W'(1);
                            r_round_key <= w_inv[RK_W-1:0];
                        end else begin
                            r_valid     <= 1'b0;
                            r_round_key <= '0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rk_valid  = r_valid;
    assign round_key = r_round_key;
    assign round_idx = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_boron_rev_key_sched.sv
// Scoreboard bench for boron_rev_key_sched: expected keys queued at start,
// a negedge monitor compares every presented key.
module tb_boron_rev_key_sched;

    localparam int unsigned R = 25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [79:0] key_in = '0;
    logic        rk_ready = 1'b1;
    logic        rk_valid;
    logic [63:0] round_key;
    logic [4:0]  round_idx;
    logic        busy;
    logic        done;

    logic        start1 = 1'b0;
    logic [79:0] key_in1 = '0;
    logic        rk_ready1 = 1'b1;
    logic        rk_valid1;
    logic [63:0] round_key1;
    logic [4:0]  round_idx1;
    logic        busy1;
    logic        done1;

    always #5 clk = ~clk;

    boron_rev_key_sched #(.ROUNDS(R)) u_dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    boron_rev_key_sched #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .key_in(key_in1),
        .rk_valid(rk_valid1), .rk_ready(rk_ready1), .round_key(round_key1),
        .round_idx(round_idx1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [63:0] key;
        logic [4:0]  idx;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        stall_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] sbox_tab = 64'h6358_F02D_AC97_1B4E;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] model_fwd(input logic [79:0] k, input int i);
        logic [79:0] r;
        logic [3:0]  n;
        r        = {k[66:0], k[79:67]};
        n        = r[3:0];
        r[3:0]   = sbox_tab[int'(n)*4 +: 4];
        r[63:59] = r[63:59] ^ 5'(i);
        return r;
    endfunction

    task automatic push_expected(input logic [79:0] k);
        logic [79:0] ks[32];
        exp_t        e;
        ks[0] = k;
        for (int i = 1; i <= int'(R); i++) ks[i] = model_fwd(ks[i-1], i);
        for (int i = int'(R); i >= 0; i--) begin
            e.key = ks[i][63:0];
            e.idx = 5'(i);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    task automatic pulse_start(input logic [79:0] k);
        start  = 1'b1;
        key_in = k;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got done=%b expected done=1 within 400 cycles", name, done);
        end
    endtask

    task automatic wait_idx(input logic [4:0] idx);
        int c;
        c = 0;
        while (!(rk_valid === 1'b1 && round_idx === idx) && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_idx", round_idx, idx);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_valid"}, rk_valid, 0);
        check({name, "_key"}, round_key, 0);
        check({name, "_idx"}, round_idx, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_k"}, u_dut.r_key, 0);
    endtask

    // Consumer handshake driver; stalls about 30% of cycles when enabled.
    always @(posedge clk) begin
        #1;
        rk_ready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    // Monitor: every presented key must match the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("valid_held", rk_valid, 1);
            if (rk_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_key: got idx %0d key %h expected no key", round_idx, round_key);
                end else begin
                    check("rk_key", round_key, exp_q[0].key);
                    check("rk_idx", round_idx, exp_q[0].idx);
                    if (rk_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = (rk_valid === 1'b1) && !rk_ready;
        end
    end

    initial begin
        logic [79:0] k;
        logic [79:0] ka;
        logic [79:0] kb;

        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;

        // Zero key: latency, hand-computed last keys, done pulse.
        push_expected('0);
        pulse_start('0);
        for (int n = 1; n <= 2*int'(R) + 2; n++) begin
            @(posedge clk); #1;
            if (n == int'(R) - 1) check("pre_valid", rk_valid, 0);
            if (n == int'(R)) begin
                check("lat_valid", rk_valid, 1);
                check("lat_idx", round_idx, 25);
            end
            if (n == 2*int'(R) - 1) begin
                check("idx1_idx", round_idx, 1);
                check("idx1_key", round_key, 64'h0800_0000_0000_000E);
            end
            if (n == 2*int'(R)) begin
                check("idx0_idx", round_idx, 0);
                check("idx0_key", round_key, 0);
            end
            if (n == 2*int'(R) + 1) begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
            end
            if (n == 2*int'(R) + 2) check("done_once", done, 0);
        end
        check("rt_zero", u_dut.r_key, 0);
        check("q_empty0", exp_q.size(), 0);

        // Random key, no stalls, then same key under backpressure.
        k = rand80();
        push_expected(k);
        pulse_start(k);
        wait_done("rand");
        check("rt_rand", u_dut.r_key, k);
        check("q_empty1", exp_q.size(), 0);

        stall_en = 1'b1;
        push_expected(k);
        pulse_start(k);
        wait_done("stall");
        stall_en = 1'b0;
        check("rt_stall", u_dut.r_key, k);
        check("q_empty2", exp_q.size(), 0);

        // start while busy is ignored; start on the done cycle is accepted.
        ka = rand80();
        kb = rand80();
        push_expected(ka);
        pulse_start(ka);
        repeat (4) @(posedge clk);
        #1;
        pulse_start(kb);
        wait_idx(5'd12);
        pulse_start(kb);
        wait_done("ignore");
        check("rt_ignore", u_dut.r_key, ka);
        push_expected(kb);
        pulse_start(kb);
        check("restart_busy", busy, 1);
        wait_done("restart");
        check("rt_restart", u_dut.r_key, kb);
        check("q_empty3", exp_q.size(), 0);

        // Reset mid-EXPAND and mid-STREAM.
        pulse_start(ka);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_cleared("rst_exp");

        push_expected(ka);
        pulse_start(ka);
        wait_idx(5'd12);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        check_cleared("rst_str");

        k = rand80();
        push_expected(k);
        pulse_start(k);
        wait_done("post_rst");
        check("rt_post_rst", u_dut.r_key, k);
        check("q_empty4", exp_q.size(), 0);

        // ROUNDS = 1 instance with zero key.
        start1  = 1'b1;
        key_in1 = '0;
        @(posedge clk); #1;
        start1  = 1'b0;
        @(posedge clk); #1;
        check("r1_valid1", rk_valid1, 1);
        check("r1_idx1", round_idx1, 1);
        check("r1_key1", round_key1, 64'h0800_0000_0000_000E);
        @(posedge clk); #1;
        check("r1_valid0", rk_valid1, 1);
        check("r1_idx0", round_idx1, 0);
        check("r1_key0", round_key1, 0);
        @(posedge clk); #1;
        check("r1_done", done1, 1);
        check("r1_busy", busy1, 0);
        check("r1_valid_end", rk_valid1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/boron_rev_key_sched.md
Name: boron_rev_key_sched

Overview:
- Reverse-order round-key generator for the BORON decryption path (64-bit block, 80-bit key).
- On start it expands the 80-bit key forward to the last round key, one step per cycle.
- It then streams the round keys K_R down to K_0 over a valid/ready handshake, undoing one key-schedule step per accepted key.
- It sits beside the Decoder, so the Decoder needs no stored key table.

Parameters:
- ROUNDS, 25, number of key-schedule steps; legal range 1..31.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- key_in  input  80  master key (KEY0); latched on accepted start
- rk_valid  output  1  round_key/round_idx valid
- rk_ready  input  1  consumer accepts current key
- round_key  output  64  current round key = K[63:0]
- round_idx  output  5  index i of the key presented (ROUNDS..0)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after K_0 is accepted

Behaviour:
- Key register K is 80 bits. S-box S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}. Inverse S-box = {A,3,9,E,1,D,F,4,C,5,7,2,6,8,0,B}.
- Forward step i (i = 1..ROUNDS):
  - K = K rotated left 13.
  - K[3:0] = S(K[3:0]).
  - K[63:59] ^= i[4:0].
- Inverse step i applies the exact reverse, in this order:
  - K[63:59] ^= i[4:0].
  - K[3:0] = invS(K[3:0]).
  - K = K rotated right 13.
- Round key RK_i = K[63:0] after i forward steps. RK_0 = key_in[63:0].
- Reset: state = IDLE; K = 0; counter = 0; rk_valid = 0; round_key = 0; round_idx = 0; busy = 0; done = 0.
- Reset has priority over every other event, including mid-expand and mid-stream. There is no partial output after reset.
- States and transitions:
  - IDLE: if start, then K <= key_in, cnt <= 1, go to EXPAND. Otherwise hold.
  - EXPAND: apply forward step cnt. If cnt == ROUNDS, go to STREAM with idx <= ROUNDS. Otherwise cnt <= cnt+1.
  - STREAM: rk_valid = 1; round_key = K[63:0]; round_idx = idx.
    - On rk_valid & rk_ready with idx != 0: apply inverse step idx, idx <= idx-1, stay in STREAM.
    - On rk_valid & rk_ready with idx == 0: go to IDLE and assert done for exactly the next cycle.
  - done is asserted in IDLE on the cycle after the final handshake. busy is 0 in that cycle.
- Latency: start accepted at edge 0 gives rk_valid = 1 with round_idx = ROUNDS on the cycle after edge ROUNDS, i.e. ROUNDS+1 cycles after start.
- Throughput: with rk_ready held high, one key per cycle. A full stream takes ROUNDS+1 handshakes, so one full run is 2*ROUNDS+2 cycles from start to done.
- Backpressure: while rk_ready = 0, round_key, round_idx and K are stable and rk_valid stays 1. rk_valid never deasserts without a handshake except on reset.
- start while busy is ignored, with no effect on K or the counters. start in the same cycle as the done pulse is accepted, because the state is IDLE.
- rk_ready outside STREAM is ignored.
- After the final handshake, K equals the latched key_in exactly. This is a round-trip invariant.
- round_key, round_idx and rk_valid are registered outputs; there is no combinational path from rk_ready to them.
- ROUNDS = 1 is legal: one expand cycle, then two keys (idx 1, idx 0).

Test Plan:
- Reset, then key_in = 0, start, rk_ready = 1:
  - first key appears 26 cycles after start with round_idx = 25;
  - keys stream for idx 25..0 on consecutive cycles;
  - idx 1 presents 64'h0800_0000_0000_000E;
  - idx 0 presents 64'h0;
  - done pulses once.
- Random key_in, rk_ready = 1: the 26 streamed keys equal a software forward schedule reversed. After done, internal K == key_in (80 bits).
- Random rk_ready with 30% low duty: the sequence is identical to the no-stall run; outputs are stable every cycle ready is low; rk_valid is never dropped.
- start pulsed at cycle 5 of EXPAND and again mid-STREAM with a different key: it is ignored and the stream matches the original key. start on the done cycle begins a new run with the new key.
- reset asserted mid-EXPAND (cycle 10) and mid-STREAM (idx 12): next cycle all outputs are 0 and the state is IDLE. A new start then runs cleanly.
- ROUNDS = 1 build, key_in = 0:
  - first key 64'h0800_0000_0000_000E with idx 1;
  - then 64'h0 with idx 0;
  - done is asserted 4 cycles after start with rk_ready = 1.
